mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Initiator-side front end for the signed MAC datapath.
- Accepts a vector of signed operand pairs over a valid/ready stream and buffers it.
- Clears the MAC, streams one pair per cycle into the MAC's a/b inputs, waits out the MAC pipeline latency, then captures the MAC result.
- Returns the captured dot product on a valid/ready output stream.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH.
- DEPTH, 8, maximum pairs per vector (buffer size).
- MAC_LAT, 2, cycles from a pair being driven on mac_a/mac_b until its product appears in mac_result.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input pair valid
- in_ready  output  1  block can accept a pair
- in_a  input  WIDTH  signed operand A
- in_b  input  WIDTH  signed operand B
- in_last  input  1  marks final pair of vector
- mac_clr  output  1  synchronous clear to MAC (drives MAC rst)
- mac_a  output  WIDTH  operand A to MAC
- mac_b  output  WIDTH  operand B to MAC
- mac_result  input  2*WIDTH  MAC accumulator value
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  2*WIDTH  captured dot product
- out_count  output  $clog2(DEPTH+1)  pairs in the vector that produced out_data
- busy  output  1  high in every state except LOAD

Behaviour:
- Reset (rst=1 at posedge): state=LOAD, pair count=0, out_valid=0, out_data=0, out_count=0, mac_a=mac_b=0.
- mac_clr = rst OR (state==CLEAR), combinational, so the MAC is also cleared during reset.
- States:
  - LOAD: in_ready=1. A pair is written to buffer[count] on in_valid&&in_ready. Go to CLEAR when the accepted pair has in_last=1 or count reaches DEPTH (in_last ignored/implied at DEPTH). A vector always holds N>=1 pairs.
  - CLEAR: exactly 1 cycle; mac_clr=1, mac_a=mac_b=0, in_ready=0.
  - ISSUE: N cycles; cycle i drives buffer[i] on mac_a/mac_b for i=0..N-1.
  - DRAIN: MAC_LAT cycles; mac_a=mac_b=0, so zero products are added. At the edge ending the last DRAIN cycle, latch out_data<=mac_result and out_count<=N.
  - DONE: out_valid=1, out_data and out_count held stable. On out_valid&&out_ready go to LOAD, count<=0, out_valid<=0.
- in_ready=0 outside LOAD; pairs offered then are not consumed.
- Latency: if the last pair is accepted at edge E0, out_valid is first high in cycle N+2+MAC_LAT after E0.
- Arithmetic: no math in this block; out_data is the MAC's two's-complement sum wrapped modulo 2^(2*WIDTH).
- Reset in any state aborts the vector, discards the buffer and drops out_valid in the next cycle.

Optional Feature:
- MAC_SEQ_CHECK_EN defined:
  - Adds output chk_err (1 bit, reset 0).
  - A shadow accumulator sums the sign-extended products of the issued pairs, modulo 2^(2*WIDTH).
  - At the capture edge the shadow sum is compared to mac_result; on mismatch chk_err is set and stays set (sticky) until rst.
- Not defined: chk_err port and shadow logic absent; behaviour otherwise identical.

Test Plan:
- Pairs (1,4),(2,5),(3,6+last), out_ready=1 -> out_data=0x0020, out_count=3, out_valid in cycle 7 after last handshake; mac_clr high exactly 1 cycle.
- Single pair (0xFF,0x05,last) -> out_data=0xFFFB (-5), out_count=1.
- Three pairs (0x80,0x80), last on third -> out_data=0xC000; four such pairs -> 0x0000 (wrap).
- Eight pairs (1,1), in_last never asserted, DEPTH=8 -> auto-terminate after 8th pair, in_ready=0 next cycle, out_data=0x0008, out_count=8.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0; accept on 6th cycle, in_ready=1 the cycle after.
- rst pulsed 1 cycle during ISSUE -> mac_clr=1 in that cycle, out_valid=0, busy=0, in_ready=1 next cycle; new vector (2,3,last) -> out_data=0x0006.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_sequencer
// Purpose  : Initiator-side front end for a signed MAC datapath. Buffers a
//            vector of signed operand pairs, clears the MAC, streams the pairs
//            one per cycle, waits out the MAC pipeline, and returns the
//            captured dot product on a valid/ready stream.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            in_valid/in_ready/in_a/in_b/in_last - operand-pair input stream
//            mac_clr, mac_a, mac_b     - drive to MAC (mac_clr = MAC reset)
//            mac_result                - MAC accumulator value
//            out_valid/out_ready/out_data/out_count - result stream
//            busy                      - high whenever not in LOAD
//            chk_err                   - sticky shadow-check error
//                                        (only with MAC_SEQ_CHECK_EN defined)
// Options  : MAC_SEQ_CHECK_EN - adds shadow accumulator and chk_err output.
// Revision : 1.0 - initial release
// ============================================================================
module mac_dot_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic                         in_last,
  output logic                         mac_clr,
  output logic [WIDTH-1:0]             mac_a,
  output logic [WIDTH-1:0]             mac_b,
  input  logic [2*WIDTH-1:0]           mac_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0]   out_count,
`ifdef MAC_SEQ_CHECK_EN
  output logic                         chk_err,
`endif
  output logic                         busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT+1) : 1;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;      // pairs held in the buffer
  logic [CW-1:0]     idx;        // next buffer slot to issue
  logic [DW-1:0]     drain_cnt;
  logic [WIDTH-1:0]  mem_a [DEPTH];
  logic [WIDTH-1:0]  mem_b [DEPTH];

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_LOAD);
  // Combinational so the MAC is held clear for the whole reset as well.
  assign mac_clr  = rst || (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      count     <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            mem_a[count[IW-1:0]] <= in_a;
            mem_b[count[IW-1:0]] <= in_b;
            count <= count + 1'b1;
            // A full buffer terminates the vector even without in_last.
            if (in_last || (count == CW'(DEPTH-1)))
              state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // mac_a/mac_b are registered: preload slot 0 for ISSUE cycle 0.
          mac_a <= mem_a[0];
          mac_b <= mem_b[0];
          idx   <= CW'(1);
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (idx == count) begin
            mac_a     <= '0;
            mac_b     <= '0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            mac_a <= mem_a[idx[IW-1:0]];
            mac_b <= mem_b[idx[IW-1:0]];
            idx   <= idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(MAC_LAT-1)) begin
            out_data  <= mac_result;
            out_count <= count;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= '0;
            state     <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef MAC_SEQ_CHECK_EN
  // Shadow sum of the pairs actually presented to the MAC during ISSUE.
  logic signed [2*WIDTH-1:0] shadow_prod;
  logic        [2*WIDTH-1:0] shadow_acc;

  assign shadow_prod = $signed(mac_a) * $signed(mac_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_acc <= '0;
      chk_err    <= 1'b0;
    end else begin
      if (state == S_CLEAR)
        shadow_acc <= '0;
      else if (state == S_ISSUE)
        shadow_acc <= shadow_acc + shadow_prod;
      if ((state == S_DRAIN) && (drain_cnt == DW'(MAC_LAT-1)) &&
          (shadow_acc != mac_result))
        chk_err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_dot_sequencer
// Purpose  : Self-checking bench for mac_dot_sequencer. Contains a simple
//            two-stage signed MAC (multiply register, then accumulate) to
//            close the loop, a plain-arithmetic dot-product reference, and a
//            scoreboard monitor that compares every accepted result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_dot_sequencer;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int MAC_LAT = 2;
  localparam int CW      = $clog2(DEPTH+1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a = '0;
  logic [WIDTH-1:0]     in_b = '0;
  logic                 in_last = 1'b0;
  logic                 mac_clr;
  logic [WIDTH-1:0]     mac_a, mac_b;
  logic [2*WIDTH-1:0]   mac_result;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [2*WIDTH-1:0]   out_data;
  logic [CW-1:0]        out_count;
  logic                 busy;

  always #5 clk = ~clk;

  mac_dot_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .busy(busy)
  );

  // Two-cycle MAC: product registered, then added into the accumulator.
  logic signed [2*WIDTH-1:0] mac_prod;
  logic        [2*WIDTH-1:0] mac_acc;
  always @(posedge clk) begin
    if (mac_clr) begin
      mac_prod <= '0;
      mac_acc  <= '0;
    end else begin
      mac_prod <= $signed(mac_a) * $signed(mac_b);
      mac_acc  <= mac_acc + mac_prod;
    end
  end
  assign mac_result = mac_acc;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int clr_cnt = 0;
  bit rand_ready = 1'b0;

  logic [15:0] exp_data_q [$];
  int          exp_count_q [$];
  logic [15:0] last_data;
  int          last_count;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mac_clr) clr_cnt <= clr_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: signed dot product, wrapped to the result width.
  function automatic logic [15:0] ref_dot(input logic [7:0] a[$], input logic [7:0] b[$]);
    int sum = 0;
    for (int i = 0; i < a.size(); i++)
      sum += int'($signed(a[i])) * int'($signed(b[i]));
    return sum[15:0];
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_result", 32'(out_data), 32'hDEAD_BEEF);
      end else begin
        logic [15:0] ed;
        int ec;
        ed = exp_data_q.pop_front();
        ec = exp_count_q.pop_front();
        chk("sb_out_data", 32'(out_data), 32'(ed));
        chk("sb_out_count", 32'(out_count), 32'(ec));
        last_data  = out_data;
        last_count = int'(out_count);
      end
    end
  end

  // Random output back-pressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Send a vector; called and returns at posedge+1. Pushes the expectation.
  task automatic send_vec(input logic [7:0] a[$], input logic [7:0] b[$], input bit use_last);
    for (int i = 0; i < a.size(); i++) begin
      bit rdy;
      int to = 0;
      in_valid = 1'b1;
      in_a     = a[i];
      in_b     = b[i];
      in_last  = use_last && (i == a.size() - 1);
      do begin
        @(negedge clk); rdy = in_ready;
        @(posedge clk); #1;
        to++;
      end while (!rdy && to < 200);
      if (!rdy) begin
        chk("send_timeout", 32'(to), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_data_q.push_back(ref_dot(a, b));
    exp_count_q.push_back(a.size());
  endtask

  task automatic wait_idle();
    int to = 0;
    while ((exp_data_q.size() != 0 || busy) && to < 500) begin
      @(negedge clk); to++;
    end
    if (to >= 500) chk("idle_timeout", 32'(to), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int e0, to;
    logic [15:0] d0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mac_clr_in_reset", 32'(mac_clr), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mac_ab", 32'({mac_a, mac_b}), 32'd0);
    chk("rst_mac_clr_low", 32'(mac_clr), 32'd0);
    @(posedge clk); #1;

    // (1,4),(2,5),(3,6) : latency and single clear cycle
    clr_cnt = 0;
    qa = '{8'd1, 8'd2, 8'd3}; qb = '{8'd4, 8'd5, 8'd6};
    send_vec(qa, qb, 1'b1);
    e0 = cyc;
    to = 0;
    do begin @(negedge clk); to++; end while (!out_valid && to < 50);
    chk("latency_cycles", 32'(cyc - e0 + 1), 32'd7);
    chk("mac_clr_one_cycle", 32'(clr_cnt), 32'd1);
    wait_idle();
    chk("dot_123_456", 32'(last_data), 32'h0020);
    chk("dot_123_count", 32'(last_count), 32'd3);

    // Single negative pair
    qa = '{8'hFF}; qb = '{8'h05};
    send_vec(qa, qb, 1'b1);
    wait_idle();
    chk("dot_neg5", 32'(last_data), 32'hFFFB);
    chk("dot_neg5_count", 32'(last_count), 32'd1);

    // 0x80 * 0x80 sums and wrap
    qa = '{8'h80, 8'h80, 8'h80}; qb = '{8'h80, 8'h80, 8'h80};
    send_vec(qa, qb, 1'b1);
    wait_idle();
    chk("dot_3x80", 32'(last_data), 32'hC000);
    qa.push_back(8'h80); qb.push_back(8'h80);
    send_vec(qa, qb, 1'b1);
    wait_idle();
    chk("dot_4x80_wrap", 32'(last_data), 32'h0000);

    // Eight pairs without in_last: auto-terminate at DEPTH
    qa.delete(); qb.delete();
    for (int i = 0; i < DEPTH; i++) begin qa.push_back(8'd1); qb.push_back(8'd1); end
    send_vec(qa, qb, 1'b0);
    @(negedge clk);
    chk("full_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    wait_idle();
    chk("dot_full", 32'(last_data), 32'h0008);
    chk("dot_full_count", 32'(last_count), 32'd8);

    // Back-pressure held in DONE for 5 cycles
    out_ready = 1'b0;
    qa = '{8'd5, 8'hFD}; qb = '{8'd7, 8'd2};
    send_vec(qa, qb, 1'b1);
    to = 0;
    do begin @(negedge clk); to++; end while (!out_valid && to < 50);
    d0 = out_data;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", 32'(out_data), 32'(d0));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_accept_in_ready", 32'(in_ready), 32'd1);
    chk("post_accept_valid", 32'(out_valid), 32'd0);
    chk("hold_result", 32'(last_data), 32'h001D);
    @(posedge clk); #1;

    // Reset during ISSUE aborts the vector
    qa = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9}; qb = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    send_vec(qa, qb, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("issue_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mac_clr", 32'(mac_clr), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_data_q.delete(); exp_count_q.delete();
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    qa = '{8'd2}; qb = '{8'd3};
    send_vec(qa, qb, 1'b1);
    wait_idle();
    chk("after_abort", 32'(last_data), 32'h0006);

    // Random vectors with random back-pressure
    rand_ready = 1'b1;
    for (int v = 0; v < 25; v++) begin
      int n;
      bit ul;
      n = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(8'($urandom));
        qb.push_back(8'($urandom));
      end
      send_vec(qa, qb, ul);
    end
    wait_idle();
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
